wb_mem_model: RTL and testbench
===============================

# wb_mem_model

Pipelined Wishbone (B4) responder modelling a word-addressed RAM for simulation benches. It accepts requests from a bus master, commits writes with byte-lane selects, and returns reads in order after a fixed, parameterised latency. It can inject pseudo-random stalls and bus errors so that bench masters can be exercised under back-pressure and fault conditions. It sits on the slave side of any Wishbone master under test.

## Interface

Parameters:
- `AW`, 5: word address width; memory depth is 2^AW words.
- `DW`, 32: data width; must be a multiple of 8.
- `LATENCY`, 1: number of cycles from request acceptance to response. Legal range is 1..16.
- `OPT_STALL`, 1'b0: enables pseudo-random stall injection.
- `STALL_SEED`, 16'hACE1: LFSR reset value. Must be nonzero.
- `OPT_ERR`, 1'b0: enables the error address.
- `ERR_ADDR`, {AW{1'b1}}: word address that returns `err` instead of `ack` when `OPT_ERR` is set.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_reset`, in, 1: reset; synchronous and active-high.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we`, in, 1 each: bus cycle, strobe and write enable.
- `i_wb_addr`, in, AW: word address.
- `i_wb_data`, in, DW: write data.
- `i_wb_sel`, in, DW/8: byte-lane selects.
- `o_wb_stall`, out, 1: stall, registered.
- `o_wb_ack`, out, 1: acknowledge, registered.
- `o_wb_data`, out, DW: read data, registered.
- `o_wb_err`, out, 1: bus error, registered.
- `o_nreads`, out, 32: count of completed read acks.
- `o_nwrites`, out, 32: count of completed write acks.

## Operation

- **Acceptance.** A request is accepted when `i_wb_cyc && i_wb_stb && !o_wb_stall` is true at a rising edge.
- **Writes.**
  - An accepted write updates each byte lane b whose `i_wb_sel[b]` is set, at the acceptance edge.
  - A write to `ERR_ADDR` is not committed when `OPT_ERR` is set.
- **Reads.** An accepted read captures the memory word at the acceptance edge. A read pipelined directly behind a write to the same address therefore returns the new data.
- **Memory contents.** Memory initialises to zero at time 0. Reset does not clear memory.
- **Response pipeline.**
  - The response pipeline is a LATENCY-deep shift register of {valid, err, we, data}.
  - Stage 0 loads on acceptance. All stages shift every clock.
  - The outputs are driven from the last stage: `o_wb_ack = valid && !err`, `o_wb_err = valid && err`.
  - `o_wb_data` carries the read data on a read ack and 0 otherwise.
- **Ordering.** Responses are returned in acceptance order, exactly one per accepted request. The block never stalls internally, because pipeline occupancy is bounded by LATENCY.
- **Abort.**
  - When `i_wb_cyc` is low at an edge, every valid bit is cleared.
  - Pending responses are discarded. Writes already accepted remain committed.
- **After an error.** Subsequent in-flight responses are still delivered while `i_wb_cyc` remains high. The master is expected to drop `cyc`, and that drop clears them.
- **Stall generator.**
  - A 16-bit Fibonacci LFSR with taps 16, 14, 13, 11 shifts every clock, feeding back into bit 0.
  - The registered stall is `o_wb_stall <= OPT_STALL && (lfsr[1:0] == 2'b11)`, which stalls about 25% of cycles.
  - The stall is independent of the bus inputs. With `OPT_STALL` = 0, `o_wb_stall` is constantly 0.
- **Counters.**
  - `o_nreads` increments on each read ack; `o_nwrites` increments on each write ack. Errors count in neither.
  - Both counters wrap modulo 2^32.

## Timing

- **Reset values.**
  - `o_wb_stall`, `o_wb_ack`, `o_wb_err` = 0; `o_wb_data` = 0.
  - All pipeline valid bits = 0.
  - lfsr = `STALL_SEED`.
  - `o_nreads` = `o_nwrites` = 0.
- **Latency.** A request accepted at edge k produces `ack`/`err` for exactly one cycle, visible after edge k+LATENCY-1. With LATENCY=1, the response follows the acceptance edge immediately.
- **Throughput.** One request per clock when not stalled. Back-to-back accepts give back-to-back acks.
- **Reset mid-burst.** All responses are dropped. No `ack` or `err` is asserted in the cycle after the reset edge.
- **Cyc drop coinciding with acceptance.** If `cyc` is low, there is no acceptance, so the two cannot coincide.
- **Response in the drop cycle.** A response already in the last stage may still be visible in the cycle `cyc` first goes low. Masters ignore it per B4.
- **Stall timing.** The stall changes only at clock edges. A strobe held during a stall is accepted at the first edge with `o_wb_stall` = 0.

## Test plan

1. **Single write then read.** LATENCY=1: write 0xDEADBEEF to addr 3, then read addr 3. Expect an ack one cycle after each accept, read data 0xDEADBEEF, and `o_nwrites` = 1, `o_nreads` = 1.
2. **Byte lanes.** Write 0x11223344 with sel=4'hF, then 0xAABBCCDD with sel=4'b0101. A read must return 0x11BB33DD.
3. **Pipelined burst.** LATENCY=4: issue 8 back-to-back reads of addrs 0..7, preloaded with value = 0x100+addr. Expect 8 consecutive acks beginning 4 cycles after the first accept, with data 0x100..0x107 in order.
4. **Error injection.** `OPT_ERR`=1, `ERR_ADDR`=5: write 0x55 to addr 5. Expect `o_wb_err` for one cycle and no ack. A later read of addr 5 gives `err`, and the memory word is unchanged (0). `o_nwrites` does not increment.
5. **Abort and reset.**
   - LATENCY=3: issue 4 reads, then drop `cyc` after 2 acks. No further acks appear.
   - Repeat with `i_reset` pulsed mid-burst: all outputs return to their reset values the next cycle, and the counters read 0.
6. **Stall soak.** `OPT_STALL`=1: a bus master performs 1000 random read/write operations against a shadow model. All read data matches, ack count equals request count, and stall is observed asserted at least 150 times.

Source files
------------

// File: rtl/wb_mem_model.sv
// Pipelined Wishbone B4 RAM responder for simulation benches; optional stall and error injection.
// Latency: response visible LATENCY-1 cycles after the acceptance edge (LATENCY=1: right after it).
// Backpressure: o_wb_stall comes from an LFSR only, never from occupancy; responses cannot be held off.
// Ports: i_clk/i_reset (sync, active-high); i_wb_cyc/stb/we/addr/data/sel request side;
//        o_wb_stall/ack/err/data response side; o_nreads/o_nwrites completed-ack counters.
module wb_mem_model #(
  parameter int              AW         = 5,
  parameter int              DW         = 32,
  parameter int              LATENCY    = 1,
  parameter logic            OPT_STALL  = 1'b0,
  parameter logic [15:0]     STALL_SEED = 16'hACE1,
  parameter logic            OPT_ERR    = 1'b0,
  parameter logic [AW-1:0]   ERR_ADDR   = {AW{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [DW-1:0]     i_wb_data,
  input  logic [DW/8-1:0]   i_wb_sel,
  output logic              o_wb_stall,
  output logic              o_wb_ack,
  output logic [DW-1:0]     o_wb_data,
  output logic              o_wb_err,
  output logic [31:0]       o_nreads,
  output logic [31:0]       o_nwrites
);

  localparam int SW   = DW / 8;
  localparam int LAST = LATENCY - 1;

  // Memory starts out zeroed and is deliberately left untouched by reset.
  logic [DW-1:0] mem [0:(2**AW)-1] = '{default: '0};

  logic accept;
  logic req_err;

  assign accept  = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign req_err = OPT_ERR && (i_wb_addr == ERR_ADDR);

  // Writes to the error address are dropped so the word stays as it was.
  always_ff @(posedge i_clk) begin
    if (accept && i_wb_we && !req_err) begin
      for (int b = 0; b < SW; b++) begin
        if (i_wb_sel[b]) mem[i_wb_addr][8*b +: 8] <= i_wb_data[8*b +: 8];
      end
    end
  end

  // Response pipeline: stage 0 loads on acceptance, the last stage drives the bus.
  logic [LATENCY-1:0] p_vld;
  logic [LATENCY-1:0] p_err;
  logic [LATENCY-1:0] p_we;
  logic [DW-1:0]      p_dat [LATENCY];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      p_vld <= '0;
    end else begin
      p_vld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) p_vld[i] <= p_vld[i-1];
      // Dropping cyc abandons everything in flight; this overrides the shift.
      if (!i_wb_cyc) p_vld <= '0;
    end
  end

  // Payload needs no reset: it is only observed through the valid bits.
  always_ff @(posedge i_clk) begin
    p_err[0] <= req_err;
    p_we[0]  <= i_wb_we;
    p_dat[0] <= (i_wb_we || req_err) ? '0 : mem[i_wb_addr];
    for (int i = 1; i < LATENCY; i++) begin
      p_err[i] <= p_err[i-1];
      p_we[i]  <= p_we[i-1];
      p_dat[i] <= p_dat[i-1];
    end
  end

  assign o_wb_ack  = p_vld[LAST] && !p_err[LAST];
  assign o_wb_err  = p_vld[LAST] && p_err[LAST];
  assign o_wb_data = (o_wb_ack && !p_we[LAST]) ? p_dat[LAST] : '0;

  // Stall generator: Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running.
  logic [15:0] lfsr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lfsr       <= STALL_SEED;
      o_wb_stall <= 1'b0;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      o_wb_stall <= OPT_STALL && (lfsr[1:0] == 2'b11);
    end
  end

  // Completed-ack counters; error responses count in neither.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_nreads  <= '0;
      o_nwrites <= '0;
    end else begin
      if (o_wb_ack && !p_we[LAST]) o_nreads  <= o_nreads + 32'd1;
      if (o_wb_ack && p_we[LAST])  o_nwrites <= o_nwrites + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_mem_model.sv
// Directed bench for wb_mem_model: four instances cover LATENCY=1 with error address,
// LATENCY=4 burst, LATENCY=3 abort/reset, and a stall soak against a shadow memory.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_wb_mem_model;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [4];
  logic        cyc  [4];
  logic        stb  [4];
  logic        we   [4];
  logic [4:0]  adr  [4];
  logic [31:0] wdat [4];
  logic [3:0]  sel  [4];
  logic        stall[4];
  logic        ack  [4];
  logic        err  [4];
  logic [31:0] rdat [4];
  logic [31:0] nrd  [4];
  logic [31:0] nwr  [4];

  int ntests = 0;
  int nfail  = 0;

  wb_mem_model #(.AW(5), .DW(32), .LATENCY(1), .OPT_STALL(1'b0), .STALL_SEED(16'hACE1),
                 .OPT_ERR(1'b1), .ERR_ADDR(5'd5)) u0 (
    .i_clk(clk), .i_reset(rst[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
    .i_wb_addr(adr[0]), .i_wb_data(wdat[0]), .i_wb_sel(sel[0]), .o_wb_stall(stall[0]),
    .o_wb_ack(ack[0]), .o_wb_data(rdat[0]), .o_wb_err(err[0]), .o_nreads(nrd[0]),
    .o_nwrites(nwr[0]));

  wb_mem_model #(.AW(5), .DW(32), .LATENCY(4), .OPT_STALL(1'b0), .STALL_SEED(16'hACE1),
                 .OPT_ERR(1'b0), .ERR_ADDR(5'd31)) u1 (
    .i_clk(clk), .i_reset(rst[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
    .i_wb_addr(adr[1]), .i_wb_data(wdat[1]), .i_wb_sel(sel[1]), .o_wb_stall(stall[1]),
    .o_wb_ack(ack[1]), .o_wb_data(rdat[1]), .o_wb_err(err[1]), .o_nreads(nrd[1]),
    .o_nwrites(nwr[1]));

  wb_mem_model #(.AW(5), .DW(32), .LATENCY(3), .OPT_STALL(1'b0), .STALL_SEED(16'hACE1),
                 .OPT_ERR(1'b0), .ERR_ADDR(5'd31)) u2 (
    .i_clk(clk), .i_reset(rst[2]), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]), .i_wb_we(we[2]),
    .i_wb_addr(adr[2]), .i_wb_data(wdat[2]), .i_wb_sel(sel[2]), .o_wb_stall(stall[2]),
    .o_wb_ack(ack[2]), .o_wb_data(rdat[2]), .o_wb_err(err[2]), .o_nreads(nrd[2]),
    .o_nwrites(nwr[2]));

  wb_mem_model #(.AW(5), .DW(32), .LATENCY(2), .OPT_STALL(1'b1), .STALL_SEED(16'hACE1),
                 .OPT_ERR(1'b0), .ERR_ADDR(5'd31)) u3 (
    .i_clk(clk), .i_reset(rst[3]), .i_wb_cyc(cyc[3]), .i_wb_stb(stb[3]), .i_wb_we(we[3]),
    .i_wb_addr(adr[3]), .i_wb_data(wdat[3]), .i_wb_sel(sel[3]), .o_wb_stall(stall[3]),
    .o_wb_ack(ack[3]), .o_wb_data(rdat[3]), .o_wb_err(err[3]), .o_nreads(nrd[3]),
    .o_nwrites(nwr[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic s, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    stb[n]  = s;
    we[n]   = w;
    adr[n]  = a;
    wdat[n] = d;
    sel[n]  = m;
  endtask

  // Soak bookkeeping
  logic [31:0] shadow [32];
  logic [32:0] q [$];
  logic [32:0] ent;
  int issued, acks, nstall, nerr;
  logic stall_prev;

  initial begin
    for (int n = 0; n < 4; n++) begin
      rst[n] = 1'b1;
      cyc[n] = 1'b0;
      drive(n, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
    end
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    tick();
    tick();

    // Reset state
    chk("rst_stall", {31'd0, stall[0]}, 32'd0);
    chk("rst_ack",   {31'd0, ack[0]},   32'd0);
    chk("rst_err",   {31'd0, err[0]},   32'd0);
    chk("rst_data",  rdat[0],           32'd0);
    chk("rst_nrd",   nrd[0],            32'd0);
    chk("rst_nwr",   nwr[0],            32'd0);
    chk("rst_stall_soak", {31'd0, stall[3]}, 32'd0);
    for (int n = 0; n < 4; n++) rst[n] = 1'b0;

    // 1: single write then read, LATENCY=1
    cyc[0] = 1'b1;
    drive(0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 4'hF);
    tick();
    chk("t1_wr_ack", {31'd0, ack[0]}, 32'd1);
    chk("t1_wr_err", {31'd0, err[0]}, 32'd0);
    drive(0, 1'b1, 1'b0, 5'd3, 32'd0, 4'hF);
    tick();
    chk("t1_rd_ack",  {31'd0, ack[0]}, 32'd1);
    chk("t1_rd_data", rdat[0],         32'hDEADBEEF);
    chk("t1_nwr",     nwr[0],          32'd1);
    drive(0, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
    tick();
    chk("t1_idle_ack", {31'd0, ack[0]}, 32'd0);
    chk("t1_nrd",      nrd[0],          32'd1);

    // 2: byte lanes
    drive(0, 1'b1, 1'b1, 5'd2, 32'h11223344, 4'hF);
    tick();
    drive(0, 1'b1, 1'b1, 5'd2, 32'hAABBCCDD, 4'b0101);
    tick();
    drive(0, 1'b1, 1'b0, 5'd2, 32'd0, 4'hF);
    tick();
    chk("t2_rd_ack",  {31'd0, ack[0]}, 32'd1);
    chk("t2_rd_data", rdat[0],         32'h11BB33DD);

    // 4: error address
    drive(0, 1'b1, 1'b1, 5'd5, 32'h00000055, 4'hF);
    tick();
    chk("t4_wr_err", {31'd0, err[0]}, 32'd1);
    chk("t4_wr_ack", {31'd0, ack[0]}, 32'd0);
    drive(0, 1'b1, 1'b0, 5'd5, 32'd0, 4'hF);
    tick();
    chk("t4_rd_err",  {31'd0, err[0]}, 32'd1);
    chk("t4_rd_ack",  {31'd0, ack[0]}, 32'd0);
    chk("t4_rd_data", rdat[0],         32'd0);
    drive(0, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
    tick();
    chk("t4_err_once", {31'd0, err[0]}, 32'd0);
    chk("t4_mem5",     u0.mem[5],       32'd0);
    chk("t4_nwr",      nwr[0],          32'd3);
    chk("t4_nrd",      nrd[0],          32'd2);
    cyc[0] = 1'b0;

    // 3: pipelined burst, LATENCY=4
    cyc[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'b1, 1'b1, 5'(i), 32'h100 + 32'(i), 4'hF);
      tick();
    end
    drive(1, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
    repeat (6) tick();
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(1, 1'b1, 1'b0, 5'(c), 32'd0, 4'hF);
      else       drive(1, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
      tick();
      if (c >= 3 && c <= 10) begin
        chk("t3_ack",  {31'd0, ack[1]}, 32'd1);
        chk("t3_data", rdat[1],         32'h100 + 32'(c - 3));
      end else begin
        chk("t3_noack", {31'd0, ack[1]}, 32'd0);
      end
    end
    tick();
    chk("t3_nrd", nrd[1], 32'd8);
    chk("t3_nwr", nwr[1], 32'd8);
    cyc[1] = 1'b0;

    // 5a: abort after two acks, LATENCY=3
    cyc[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(2, 1'b1, 1'b0, 5'(c), 32'd0, 4'hF);
      tick();
      chk("t5_burst_ack", {31'd0, ack[2]}, (c >= 2) ? 32'd1 : 32'd0);
    end
    cyc[2] = 1'b0;
    drive(2, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_abort_ack", {31'd0, ack[2]}, 32'd0);
      chk("t5_abort_err", {31'd0, err[2]}, 32'd0);
    end
    chk("t5_abort_nrd", nrd[2], 32'd2);

    // 5b: reset mid-burst
    cyc[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(2, 1'b1, 1'b0, 5'(c), 32'd0, 4'hF);
      tick();
    end
    chk("t5_pre_rst_ack", {31'd0, ack[2]}, 32'd1);
    rst[2] = 1'b1;
    drive(2, 1'b1, 1'b0, 5'd3, 32'd0, 4'hF);
    tick();
    chk("t5_rst_ack",   {31'd0, ack[2]},   32'd0);
    chk("t5_rst_err",   {31'd0, err[2]},   32'd0);
    chk("t5_rst_stall", {31'd0, stall[2]}, 32'd0);
    chk("t5_rst_data",  rdat[2],           32'd0);
    chk("t5_rst_nrd",   nrd[2],            32'd0);
    chk("t5_rst_nwr",   nwr[2],            32'd0);
    rst[2] = 1'b0;
    drive(2, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_post_rst_ack", {31'd0, ack[2]}, 32'd0);
    end
    chk("t5_post_rst_nrd", nrd[2], 32'd0);
    cyc[2] = 1'b0;

    // 6: stall soak against a shadow memory
    issued = 0;
    acks   = 0;
    nstall = 0;
    nerr   = 0;
    cyc[3] = 1'b1;
    for (int t = 0; t < 6000 && acks < 1000; t++) begin
      if (!stb[3] && issued < 1000) begin
        drive(3, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              4'($urandom_range(0, 15)));
      end
      stall_prev = stall[3];
      if (stall_prev) nstall++;
      tick();
      if (stb[3] && !stall_prev) begin
        if (we[3]) begin
          for (int b = 0; b < 4; b++)
            if (sel[3][b]) shadow[adr[3]][8*b +: 8] = wdat[3][8*b +: 8];
          q.push_back({1'b1, 32'd0});
        end else begin
          q.push_back({1'b0, shadow[adr[3]]});
        end
        issued++;
        stb[3] = 1'b0;
      end
      if (ack[3]) begin
        chk("t6_ack_expected", {31'd0, q.size() > 0}, 32'd1);
        if (q.size() > 0) begin
          ent = q.pop_front();
          if (!ent[32]) chk("t6_rd_data", rdat[3], ent[31:0]);
        end
        acks++;
      end
      if (err[3]) nerr++;
    end
    drive(3, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
    tick();
    chk("t6_issued",    32'(issued),              32'd1000);
    chk("t6_acks",      32'(acks),                32'd1000);
    chk("t6_pending",   32'(q.size()),            32'd0);
    chk("t6_errs",      32'(nerr),                32'd0);
    chk("t6_stall_150", {31'd0, nstall >= 150},   32'd1);
    chk("t6_counters",  nrd[3] + nwr[3],          32'd1000);
    cyc[3] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
